// File: rtl/cybercobra_pro.sv
// CYBERcobra register machine: single-cycle core with run/step/halt control and a retired-instruction counter.
// Latency: an instruction retires on the edge where exec=1; its register write is visible on out_o the next cycle.
// Backpressure: none. Execution is gated only by the controller (RUN every cycle, PAUSE on step_i, HALTED never).
//
// Ports:
//   clk_i, rst_i      clock, synchronous active-low reset
//   instr_i           instruction word at pc_o (combinational ROM)
//   sw_i              SW_CH 16-bit switch channels, channel k at [16k+15:16k]
//   run_i             1 = free-run, 0 = paused (takes effect on the next edge)
//   step_i            executes one instruction per cycle while paused
//   resume_i          leaves HALTED (pc += 4, no execution that cycle)
//   pc_o              current byte address
//   out_o             RF[RA1] of the current instruction (combinational)
//   halted_o          core is in HALTED
//   instret_o         retired-instruction count, wraps at 2^32
module cybercobra_pro #(
  parameter int WIDTH = 32,
  parameter int SW_CH = 1,
  parameter int PC_W  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [31:0]           instr_i,
  input  logic [16*SW_CH-1:0]   sw_i,
  input  logic                  run_i,
  input  logic                  step_i,
  input  logic                  resume_i,
  output logic [PC_W-1:0]       pc_o,
  output logic [WIDTH-1:0]      out_o,
  output logic                  halted_o,
  output logic [31:0]           instret_o
);

  localparam int SH_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_PAUSE  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  // Instruction fields
  logic       j_bit;
  logic       b_bit;
  logic [1:0] ws;
  logic [4:0] alu_op;
  logic [4:0] ra1;
  logic [4:0] ra2;
  logic [7:0] offset;
  logic [4:0] wa;

  assign j_bit  = instr_i[31];
  assign b_bit  = instr_i[30];
  assign ws     = instr_i[29:28];
  assign alu_op = instr_i[27:23];
  assign ra1    = instr_i[22:18];
  assign ra2    = instr_i[17:13];
  assign offset = instr_i[12:5];
  assign wa     = instr_i[4:0];

  // State
  state_t               state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [31:0]          instret_q, instret_d;
  logic [WIDTH-1:0]     rf_q [32];

  // Register file read ports; x0 is forced to zero regardless of storage
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;
  assign rd1 = (ra1 == 5'd0) ? '0 : rf_q[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : rf_q[ra2];

  // ALU
  logic [WIDTH-1:0] alu_res;
  logic             alu_flag;
  logic [SH_W-1:0]  shamt;
  assign shamt = rd2[SH_W-1:0];

  always_comb begin
    alu_res  = '0;
    alu_flag = 1'b0;
    case (alu_op)
      5'b00000: alu_res = rd1 + rd2;
      5'b01000: alu_res = rd1 - rd2;
      5'b00100: alu_res = rd1 ^ rd2;
      5'b00110: alu_res = rd1 | rd2;
      5'b00111: alu_res = rd1 & rd2;
      5'b00001: alu_res = rd1 << shamt;
      5'b00101: alu_res = rd1 >> shamt;
      5'b01101: alu_res = $signed(rd1) >>> shamt;
      5'b00010: alu_res = {{(WIDTH-1){1'b0}}, ($signed(rd1) < $signed(rd2))};
      5'b00011: alu_res = {{(WIDTH-1){1'b0}}, (rd1 < rd2)};
      5'b11100: alu_flag = $signed(rd1) <  $signed(rd2);
      5'b11110: alu_flag = rd1 <  rd2;
      5'b11101: alu_flag = $signed(rd1) >= $signed(rd2);
      5'b11111: alu_flag = rd1 >= rd2;
      5'b11000: alu_flag = rd1 == rd2;
      5'b11001: alu_flag = rd1 != rd2;
      default: ;
    endcase
  end

  // Switch channel select; indices beyond the populated channels read as zero
  logic [15:0] sw_val;
  always_comb begin
    sw_val = '0;
    for (int k = 0; k < SW_CH; k++) begin
      if (alu_op == k[4:0]) sw_val = sw_i[16*k +: 16];
    end
  end

  // Write-data mux; the size casts sign-extend / zero-extend or truncate to WIDTH
  logic [WIDTH-1:0] wd;
  always_comb begin
    wd = '0;
    case (ws)
      2'd0:    wd = WIDTH'($signed(instr_i[27:5]));
      2'd1:    wd = alu_res;
      2'd2:    wd = WIDTH'(sw_val);
      default: wd = '0;
    endcase
  end

  // Controller and PC
  state_t          run_mode;
  logic            exec;
  logic            is_halt;
  logic            we;
  logic            take;
  logic [PC_W-1:0] pc_seq;
  logic [PC_W-1:0] pc_br;

  assign run_mode = run_i ? S_RUN : S_PAUSE;
  assign exec     = (state_q == S_RUN) || ((state_q == S_PAUSE) && step_i);
  assign is_halt  = !j_bit && !b_bit && (ws == 2'd3);
  assign we       = exec && !j_bit && !b_bit && (ws != 2'd3);
  // J wins over B, so B's flag only matters when J is clear
  assign take     = j_bit || (b_bit && alu_flag);
  assign pc_seq   = pc_q + PC_W'(4);
  assign pc_br    = pc_q + PC_W'($signed({offset, 2'b00}));

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instret_d = instret_q;
    case (state_q)
      S_HALTED: begin
        // Resume skips past the HALT instruction without executing anything
        if (resume_i) begin
          pc_d    = pc_seq;
          state_d = run_mode;
        end
      end
      default: begin
        state_d = run_mode;
        if (exec) begin
          instret_d = instret_q + 32'd1;
          if (take) begin
            pc_d = pc_br;
          end else if (is_halt) begin
            state_d = S_HALTED;
          end else begin
            pc_d = pc_seq;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= run_mode;
      pc_q      <= '0;
      instret_q <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instret_q <= instret_d;
      if (we && (wa != 5'd0)) rf_q[wa] <= wd;
    end
  end

  assign pc_o      = pc_q;
  assign out_o     = rd1;
  assign halted_o  = (state_q == S_HALTED);
  assign instret_o = instret_q;

endmodule

// File: tb/tb_cybercobra_pro.sv
// Bench for cybercobra_pro (WIDTH=16, SW_CH=4, PC_W=8): directed programs plus random
// programs/controls, all checked every cycle against an instruction-level model.
module tb_cybercobra_pro;

  localparam int unsigned MASK = 32'h0000_FFFF;

  logic        clk;
  logic        rst_i;
  logic [31:0] instr_i;
  logic [63:0] sw_i;
  logic        run_i;
  logic        step_i;
  logic        resume_i;
  logic [7:0]  pc_o;
  logic [15:0] out_o;
  logic        halted_o;
  logic [31:0] instret_o;

  logic [31:0] rom [64];
  assign instr_i = rom[pc_o[7:2]];

  cybercobra_pro #(.WIDTH(16), .SW_CH(4), .PC_W(8)) dut (
    .clk_i(clk), .rst_i(rst_i), .instr_i(instr_i), .sw_i(sw_i),
    .run_i(run_i), .step_i(step_i), .resume_i(resume_i),
    .pc_o(pc_o), .out_o(out_o), .halted_o(halted_o), .instret_o(instret_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model (instruction level) ----------------
  int unsigned m_rf [32];
  int unsigned m_pc;
  int unsigned m_instret;
  bit          m_halted;
  bit          m_run;
  bit          m_valid;

  function automatic int sgn16(input int unsigned v);
    return (v & 32'h8000) != 0 ? int'(v) - 65536 : int'(v);
  endfunction

  task automatic model_alu(input int unsigned op, input int unsigned a, input int unsigned b,
                           output int unsigned res, output bit flg);
    int sa;
    int sb;
    int unsigned sh;
    sa = sgn16(a);
    sb = sgn16(b);
    sh = b % 16;
    res = 0;
    flg = 0;
    case (op)
      0:  res = (a + b) & MASK;
      8:  res = (a - b) & MASK;
      4:  res = a ^ b;
      6:  res = a | b;
      7:  res = a & b;
      1:  res = (a << sh) & MASK;
      5:  res = a >> sh;
      13: res = int'(sa >>> sh) & MASK;
      2:  res = (sa < sb) ? 1 : 0;
      3:  res = (a < b) ? 1 : 0;
      28: flg = sa < sb;
      30: flg = a < b;
      29: flg = sa >= sb;
      31: flg = a >= b;
      24: flg = a == b;
      25: flg = a != b;
      default: ;
    endcase
  endtask

  task automatic model_edge();
    logic [31:0] in;
    int unsigned res;
    int unsigned wv;
    int unsigned idx;
    int off;
    int s;
    bit flg;
    if (!rst_i) begin
      for (int i = 0; i < 32; i++) m_rf[i] = 0;
      m_pc = 0; m_instret = 0; m_halted = 0; m_valid = 1; m_run = run_i;
      return;
    end
    if (!m_valid) return;
    if (m_halted) begin
      if (resume_i) begin
        m_pc = (m_pc + 4) % 256;
        m_halted = 0;
      end
      m_run = run_i;
      return;
    end
    if (m_run || step_i) begin
      in = rom[m_pc / 4];
      model_alu(in[27:23], m_rf[in[22:18]], m_rf[in[17:13]], res, flg);
      off = int'(in[12:5]);
      if (off >= 128) off -= 256;
      m_instret++;
      if (in[31] || (in[30] && flg)) begin
        m_pc = int'(int'(m_pc) + off * 4) & 255;
      end else if (in[30]) begin
        m_pc = (m_pc + 4) % 256;
      end else if (in[29:28] == 2'd3) begin
        m_halted = 1;
      end else begin
        case (in[29:28])
          2'd0: begin
            s = int'(in[27:5]);
            if (in[27]) s -= (1 << 23);
            wv = int'(s) & MASK;
          end
          2'd1: wv = res;
          default: begin
            idx = in[27:23];
            wv = (idx < 4) ? int'((sw_i >> (16 * idx)) & 64'hFFFF) : 0;
          end
        endcase
        if (in[4:0] != 0) m_rf[in[4:0]] = wv;
        m_pc = (m_pc + 4) % 256;
      end
    end
    m_run = run_i;
  endtask

  // One clock: check combinational output, advance model, sample after the edge.
  task automatic cyc();
    logic [31:0] w;
    #1;
    if (m_valid) begin
      w = rom[m_pc / 4];
      check("out_o", {16'h0, out_o}, m_rf[w[22:18]]);
    end
    model_edge();
    @(posedge clk);
    @(negedge clk);
    if (m_valid) begin
      check("pc_o", {24'h0, pc_o}, m_pc);
      check("halted_o", {31'h0, halted_o}, {31'h0, m_halted});
      check("instret_o", instret_o, m_instret);
    end
  endtask

  task automatic do_reset(input int n);
    rst_i = 1'b0;
    repeat (n) cyc();
    rst_i = 1'b1;
  endtask

  task automatic run_until_halt(input int max);
    for (int i = 0; i < max && !m_halted; i++) cyc();
    check("halt_reached", {31'h0, halted_o}, 32'd1);
  endtask

  task automatic resume_pulse();
    resume_i = 1'b1;
    cyc();
    resume_i = 1'b0;
  endtask

  // Instruction encoders
  function automatic logic [31:0] i_const(input logic [22:0] imm, input logic [4:0] wa);
    return {4'b0000, imm, wa};
  endfunction
  function automatic logic [31:0] i_alu(input logic [4:0] op, input logic [4:0] a,
                                        input logic [4:0] b, input logic [4:0] wa);
    return {4'b0001, op, a, b, 8'h00, wa};
  endfunction
  function automatic logic [31:0] i_sw(input logic [4:0] idx, input logic [4:0] wa);
    return {4'b0010, idx, 18'h0, wa};
  endfunction
  function automatic logic [31:0] i_br(input logic [4:0] op, input logic [4:0] a,
                                       input logic [4:0] b, input logic [7:0] off);
    return {4'b0100, op, a, b, off, 5'h0};
  endfunction
  function automatic logic [31:0] i_halt(input logic [4:0] a);
    return {4'b0011, 5'h0, a, 18'h0};
  endfunction

  task automatic fill_halts();
    for (int i = 0; i < 64; i++) rom[i] = i_halt(5'd0);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; m_valid = 0; m_halted = 0; m_run = 0;
    m_pc = 0; m_instret = 0;
    rst_i = 1'b0; run_i = 1'b1; step_i = 1'b0; resume_i = 1'b0; sw_i = '0;

    // Reset with random instruction words
    for (int i = 0; i < 64; i++) rom[i] = $urandom;
    do_reset(2);
    check("rst_pc", {24'h0, pc_o}, 32'd0);
    check("rst_instret", instret_o, 32'd0);
    check("rst_out", {16'h0, out_o}, 32'd0);
    check("rst_halted", {31'h0, halted_o}, 32'd0);

    // Counter program: x3 counts up to switch value 0x129
    fill_halts();
    rom[0] = i_const(23'd1, 5'd1);
    rom[1] = i_sw(5'd0, 5'd2);
    rom[2] = i_const(23'd0, 5'd3);
    rom[3] = i_alu(5'b00000, 5'd3, 5'd1, 5'd3);
    rom[4] = i_br(5'b11001, 5'd3, 5'd2, 8'hFF);
    rom[5] = i_halt(5'd3);
    sw_i = 64'h0129; run_i = 1'b1;
    do_reset(1);
    run_until_halt(700);
    check("cnt_x3", {16'h0, out_o}, 32'h129);
    check("cnt_instret", instret_o, 32'd598);
    check("cnt_pc", {24'h0, pc_o}, 32'h14);

    // 16-bit wrap, truncation and arithmetic shift
    fill_halts();
    rom[0] = i_const(23'h7FFFFF, 5'd1);
    rom[1] = i_const(23'd1, 5'd2);
    rom[2] = i_alu(5'b00000, 5'd1, 5'd2, 5'd3);
    rom[3] = i_const(23'h008000, 5'd4);
    rom[4] = i_const(23'd15, 5'd5);
    rom[5] = i_alu(5'b01101, 5'd4, 5'd5, 5'd6);
    rom[6] = i_halt(5'd1);
    rom[7] = i_halt(5'd3);
    rom[8] = i_halt(5'd6);
    do_reset(1);
    run_until_halt(20);
    check("w_const", {16'h0, out_o}, 32'hFFFF);
    resume_pulse(); run_until_halt(5);
    check("w_add_wrap", {16'h0, out_o}, 32'h0);
    resume_pulse(); run_until_halt(5);
    check("w_sra", {16'h0, out_o}, 32'hFFFF);

    // Switch channels: index 3 populated, index 5 out of range
    fill_halts();
    sw_i = {16'hBEEF, 16'h1111, 16'h2222, 16'h3333};
    rom[0] = i_const(23'h55, 5'd8);
    rom[1] = i_sw(5'd3, 5'd7);
    rom[2] = i_sw(5'd5, 5'd8);
    rom[3] = i_halt(5'd7);
    rom[4] = i_halt(5'd8);
    do_reset(1);
    run_until_halt(10);
    check("sw_ch3", {16'h0, out_o}, 32'hBEEF);
    resume_pulse(); run_until_halt(5);
    check("sw_ch5", {16'h0, out_o}, 32'h0);

    // Paused stepping
    for (int i = 0; i < 64; i++) rom[i] = i_const(23'(i + 1), 5'd1);
    run_i = 1'b0;
    do_reset(1);
    for (int k = 0; k < 3; k++) begin
      repeat (3) cyc();
      step_i = 1'b1; cyc(); step_i = 1'b0;
    end
    repeat (3) cyc();
    check("pause_pc", {24'h0, pc_o}, 32'd12);
    check("pause_instret", instret_o, 32'd3);
    step_i = 1'b1; repeat (4) cyc(); step_i = 1'b0;
    cyc();
    check("step_held_pc", {24'h0, pc_o}, 32'd28);
    check("step_held_instret", instret_o, 32'd7);

    // HALT at 0x10, hold, resume, then reset while halted
    fill_halts();
    for (int k = 0; k < 4; k++) rom[k] = i_const(23'(k + 3), 5'(k + 1));
    rom[4] = i_halt(5'd0);
    rom[5] = i_const(23'h77, 5'd9);
    rom[6] = i_halt(5'd9);
    run_i = 1'b1;
    do_reset(1);
    run_until_halt(20);
    check("halt_pc", {24'h0, pc_o}, 32'h10);
    for (int k = 0; k < 20; k++) begin
      step_i = k[0]; cyc();
    end
    step_i = 1'b0;
    check("halt_hold_pc", {24'h0, pc_o}, 32'h10);
    check("halt_hold_flag", {31'h0, halted_o}, 32'd1);
    check("halt_instret", instret_o, 32'd5);
    resume_pulse();
    check("resume_pc", {24'h0, pc_o}, 32'h14);
    check("resume_flag", {31'h0, halted_o}, 32'd0);
    run_until_halt(10);
    check("resume_exec", {16'h0, out_o}, 32'h77);
    rst_i = 1'b0; resume_i = 1'b1; cyc(); rst_i = 1'b1; resume_i = 1'b0;
    check("halt_rst_pc", {24'h0, pc_o}, 32'h0);
    check("halt_rst_flag", {31'h0, halted_o}, 32'd0);

    // Random programs and controls
    for (int i = 0; i < 64; i++) rom[i] = $urandom;
    do_reset(1);
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(15) == 0) run_i = ~run_i;
      step_i   = ($urandom_range(2) == 0);
      resume_i = ($urandom_range(3) == 0);
      rst_i    = ($urandom_range(499) != 0);
      if ($urandom_range(31) == 0) sw_i = {$urandom, $urandom};
      if ($urandom_range(63) == 0) rom[$urandom_range(63)] = $urandom;
      cyc();
    end
    rst_i = 1'b1; step_i = 1'b0; resume_i = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
